user_au_hpf_scheduler: RTL and testbench

//  Time-shares one high-pass-filter datapath across NUM_CH audio channels.
//  - Round-robin arbitration of per-channel valid/ready inputs.
//  - Holds per-channel filter history (prev input, prev output).
//  - Emits one filtered sample per grant, tagged with its channel index.
//  - Sits between the channel demux and the downstream mixer; replaces NUM_CH parallel HPF stages.

---
 rtl/user_au_hpf_pkg.sv | 35 +++
 rtl/user_au_hpf_scheduler_if.sv | 44 ++++
 rtl/user_au_rr_arbiter.sv | 31 +++
 rtl/user_au_hpf_scheduler.sv | 131 +++++++++++++
 tb/tb_user_au_hpf_scheduler.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/user_au_hpf_pkg.sv
// Shared types, state encoding and the single-step HPF recurrence used by the HPF blocks.
// Revision: 1.0
`default_nettype none

package user_au_hpf_pkg;

  typedef logic signed [31:0] sample_t;
  typedef logic signed [63:0] acc_t;

  localparam int DECAY_SHIFT_DEFAULT = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } hpf_sched_state_e;

  // y = ((decay * (x - xp + 2*yp)) >>> shift) - yp, evaluated entirely in 64 bits
  function automatic acc_t hpf_step(
    input sample_t     x,
    input sample_t     xp,
    input sample_t     yp,
    input sample_t     decay,
    input int unsigned shift = DECAY_SHIFT_DEFAULT
  );
    acc_t diff;
    acc_t prod;
    diff = acc_t'(x) - acc_t'(xp) + (acc_t'(yp) <<< 1);
    prod = acc_t'(decay) * diff;
    return (prod >>> shift) - acc_t'(yp);
  endfunction

endpackage

`default_nettype wire

// File: rtl/user_au_hpf_scheduler_if.sv
// Channel-side and mixer-side signals of the shared HPF scheduler.
// Optional USER_AU_HPF_SAT_EN adds the sticky saturation flag sat_o.
// Revision: 1.0
`default_nettype none

interface user_au_hpf_scheduler_if #(
  parameter int NUM_CH = 4
);
  import user_au_hpf_pkg::*;

  localparam int CH_W = $clog2(NUM_CH);

  sample_t             data_i [NUM_CH];
  logic [NUM_CH-1:0]   valid_i;
  logic [NUM_CH-1:0]   ready_o;
  sample_t             data_o;
  logic [CH_W-1:0]     ch_o;
  logic                valid_o;
  logic                ready_i;
  sample_t             decay_i;
  logic                clear_i;
`ifdef USER_AU_HPF_SAT_EN
  logic                sat_o;
`endif

  modport slave (
    input  data_i, valid_i, ready_i, decay_i, clear_i,
    output ready_o, data_o, ch_o, valid_o
`ifdef USER_AU_HPF_SAT_EN
    , output sat_o
`endif
  );

  modport master (
    output data_i, valid_i, ready_i, decay_i, clear_i,
    input  ready_o, data_o, ch_o, valid_o
`ifdef USER_AU_HPF_SAT_EN
    , input sat_o
`endif
  );

endinterface

`default_nettype wire

// File: rtl/user_au_rr_arbiter.sv
// Combinational round-robin arbiter: grants the lowest requester at or above ptr, else wraps.
// Revision: 1.0
`default_nettype none

module user_au_rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt_onehot,
  output logic [$clog2(N)-1:0] gnt_idx
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_sel;

  assign w_mask     = req & ({N{1'b1}} << ptr);
  assign w_sel      = (|w_mask) ? w_mask : req;
  assign gnt_onehot = w_sel & (~w_sel + N'(1));

  always_comb begin
    gnt_idx = '0;
    // Walk downward so the lowest set bit is the last one written
    for (int i = N - 1; i >= 0; i--) begin
      if (w_sel[i]) gnt_idx = $clog2(N)'(i);
    end
  end

endmodule

`default_nettype wire

// File: rtl/user_au_hpf_scheduler.sv
// Time-shares one high-pass-filter datapath across NUM_CH channels with round-robin grants.
// Define USER_AU_HPF_SAT_EN to saturate results to 32 bits and expose sticky sat_o.
// Revision: 1.0
`default_nettype none

module user_au_hpf_scheduler
  import user_au_hpf_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DECAY_SHIFT = DECAY_SHIFT_DEFAULT
) (
  input  wire logic                clk_i,
  input  wire logic                rst_i,
  user_au_hpf_scheduler_if.slave   bus
);

  localparam int CH_W = $clog2(NUM_CH);

  hpf_sched_state_e   r_state;
  logic [CH_W-1:0]    r_ptr;
  logic [CH_W-1:0]    r_ch;
  sample_t            r_x;
  sample_t            r_decay;
  sample_t            r_y;
  logic               r_valid;
  sample_t            r_xp [NUM_CH];
  sample_t            r_yp [NUM_CH];

  logic [NUM_CH-1:0]  w_gnt_onehot;
  logic [CH_W-1:0]    w_gnt_idx;
  logic               w_any;
  sample_t            w_y;

  user_au_rr_arbiter #(
    .N (NUM_CH)
  ) u_arb (
    .req        (bus.valid_i),
    .ptr        (r_ptr),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx)
  );

  assign w_any = |w_gnt_onehot;

`ifdef USER_AU_HPF_SAT_EN
  localparam acc_t c_SAT_MAX = 64'sh0000_0000_7FFF_FFFF;
  localparam acc_t c_SAT_MIN = 64'shFFFF_FFFF_8000_0000;

  acc_t  w_acc;
  logic  w_clip_hi;
  logic  w_clip_lo;
  logic  r_sat;

  assign w_acc     = hpf_step(r_x, r_xp[r_ch], r_yp[r_ch], r_decay, DECAY_SHIFT);
  assign w_clip_hi = (w_acc > c_SAT_MAX);
  assign w_clip_lo = (w_acc < c_SAT_MIN);
  assign w_y       = w_clip_hi ? 32'sh7FFF_FFFF :
                     w_clip_lo ? 32'sh8000_0000 : sample_t'(w_acc);
  assign bus.sat_o = r_sat;
`else
  assign w_y = sample_t'(hpf_step(r_x, r_xp[r_ch], r_yp[r_ch], r_decay, DECAY_SHIFT));
`endif

  // Accept only in IDLE and never while reset is being applied
  assign bus.ready_o = (r_state == IDLE && !rst_i) ? w_gnt_onehot : '0;
  assign bus.valid_o = r_valid;
  assign bus.data_o  = r_y;
  assign bus.ch_o    = r_ch;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_ch    <= '0;
      r_x     <= '0;
      r_decay <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_xp[k] <= '0;
        r_yp[k] <= '0;
      end
`ifdef USER_AU_HPF_SAT_EN
      r_sat   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_x     <= bus.data_i[w_gnt_idx];
            r_ch    <= w_gnt_idx;
            r_decay <= bus.decay_i;
            r_state <= CALC;
          end
        end
        CALC: begin
          r_y     <= w_y;
          r_valid <= 1'b1;
          r_state <= OUT;
`ifdef USER_AU_HPF_SAT_EN
          if (w_clip_hi || w_clip_lo) r_sat <= 1'b1;
`endif
        end
        OUT: begin
          if (bus.ready_i) begin
            r_valid      <= 1'b0;
            r_xp[r_ch]   <= r_x;
            r_yp[r_ch]   <= r_y;
            r_ptr        <= (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + 1'b1;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Placed after the FSM so a clear coinciding with the handshake wins
      if (bus.clear_i) begin
        for (int k = 0; k < NUM_CH; k++) begin
          r_xp[k] <= '0;
          r_yp[k] <= '0;
        end
`ifdef USER_AU_HPF_SAT_EN
        r_sat <= 1'b0;
`endif
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_user_au_hpf_scheduler.sv
// Directed self-checking bench for user_au_hpf_scheduler (checks sat_o when USER_AU_HPF_SAT_EN is set).
// Revision: 1.0
`default_nettype none

module tb_user_au_hpf_scheduler;

  localparam int NUM_CH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_total = 0;
  int   n_bad   = 0;

  always #5 clk = ~clk;

  user_au_hpf_scheduler_if #(.NUM_CH(NUM_CH)) u_if ();

  user_au_hpf_scheduler #(
    .NUM_CH      (NUM_CH),
    .DECAY_SHIFT (11)
  ) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (u_if)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One complete transfer on channel ch with ready_i high; optional clear on the handshake cycle
  task automatic xfer(input int ch, input logic signed [31:0] x, input logic signed [31:0] dec,
                      input logic signed [31:0] expy, input bit clr_hs, input string tag);
    int n;
    @(negedge clk);
    u_if.data_i[ch]  = x;
    u_if.valid_i[ch] = 1'b1;
    u_if.decay_i     = dec;
    #1;
    n = 0;
    while (u_if.ready_o[ch] !== 1'b1 && n < 16) begin
      @(negedge clk); #1; n++;
    end
    chk({tag, "_grant"}, u_if.ready_o, 64'd1 << ch);
    @(negedge clk);
    u_if.valid_i[ch] = 1'b0;
    u_if.decay_i     = 32'sh1234_5678;
    chk({tag, "_calc"}, {u_if.valid_o, u_if.ready_o}, 64'd0);
    @(negedge clk);
    chk({tag, "_valid"}, u_if.valid_o, 64'd1);
    chk({tag, "_data"}, u_if.data_o, expy);
    chk({tag, "_ch"}, u_if.ch_o, ch);
    if (clr_hs) u_if.clear_i = 1'b1;
    @(negedge clk);
    u_if.clear_i = 1'b0;
    chk({tag, "_done"}, u_if.valid_o, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int e;
    logic signed [31:0] t6_exp;

    for (int i = 0; i < NUM_CH; i++) u_if.data_i[i] = '0;
    u_if.valid_i = '0;
    u_if.ready_i = 1'b1;
    u_if.decay_i = '0;
    u_if.clear_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_valid", u_if.valid_o, 64'd0);
    chk("rst_data", u_if.data_o, 64'd0);
    chk("rst_ch", u_if.ch_o, 64'd0);
    chk("rst_ready", u_if.ready_o, 64'd0);

    // Unity gain passthrough
    xfer(0, 1000, 2048, 1000, 1'b0, "t1a");
    xfer(0, 1000, 2048, 1000, 1'b0, "t1b");
    xfer(0, -500, 2048, -500, 1'b0, "t1c");

    // Half decay step response
    xfer(1, 1000, 1024, 500, 1'b0, "t2a");
    xfer(1, 1000, 1024, 0, 1'b0, "t2b");
    xfer(1, 1000, 1024, 0, 1'b0, "t2c");

    // Downstream stall: output frozen, no new grant although ch0 is requesting
    @(negedge clk);
    u_if.ready_i    = 1'b0;
    u_if.data_i[3]  = 777;
    u_if.valid_i[3] = 1'b1;
    u_if.decay_i    = 2048;
    #1;
    n = 0;
    while (u_if.ready_o[3] !== 1'b1 && n < 16) begin
      @(negedge clk); #1; n++;
    end
    chk("t4_grant", u_if.ready_o, 64'd8);
    @(negedge clk);
    u_if.valid_i[3] = 1'b0;
    u_if.data_i[0]  = 5;
    u_if.valid_i[0] = 1'b1;
    repeat (11) begin
      @(negedge clk); #1;
      chk("t4_stall", {u_if.valid_o, u_if.ready_o, u_if.ch_o, u_if.data_o},
          {1'b1, 4'b0000, 2'd3, 32'sd777});
    end
    u_if.valid_i[0] = 1'b0;
    u_if.ready_i    = 1'b1;
    @(negedge clk);
    chk("t4_release", u_if.valid_o, 64'd0);

    // Clear coinciding with the handshake zeroes the history it would have written
    xfer(2, 1000, 1024, 500, 1'b0, "t5a");
    xfer(2, 1000, 1024, 0, 1'b1, "t5b");
    xfer(2, 1000, 1024, 500, 1'b0, "t5c");

    // Overflowing step: saturates or wraps to the low 32 bits
    @(negedge clk);
    u_if.clear_i = 1'b1;
    @(negedge clk);
    u_if.clear_i = 1'b0;
`ifdef USER_AU_HPF_SAT_EN
    t6_exp = 32'sh7FFF_FFFF;
    chk("t6_sat_pre", u_if.sat_o, 64'd0);
`else
    t6_exp = 32'shFFE0_0000;
`endif
    xfer(0, 32'sh7FFF_FFFF, 32'sh7FFF_FFFF, t6_exp, 1'b0, "t6");
`ifdef USER_AU_HPF_SAT_EN
    chk("t6_sat_set", u_if.sat_o, 64'd1);
    @(negedge clk);
    u_if.clear_i = 1'b1;
    @(negedge clk);
    u_if.clear_i = 1'b0;
    chk("t6_sat_clr", u_if.sat_o, 64'd0);
`endif

    // Reset while a sample is in CALC: it must never appear on the output
    @(negedge clk);
    u_if.data_i[1]  = 42;
    u_if.valid_i[1] = 1'b1;
    u_if.decay_i    = 2048;
    #1;
    n = 0;
    while (u_if.ready_o[1] !== 1'b1 && n < 16) begin
      @(negedge clk); #1; n++;
    end
    chk("rst_mid_grant", u_if.ready_o, 64'd2);
    @(negedge clk);
    u_if.valid_i[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_mid_drop", {u_if.valid_o, u_if.ch_o}, 64'd0);
    end

    // All channels requesting: strict rotation starting from channel 0, independent histories
    @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) u_if.data_i[i] = (i + 1) * 100;
    u_if.decay_i = 2048;
    u_if.valid_i = '1;
    #1;
    for (int g = 0; g < 2 * NUM_CH; g++) begin
      e = g % NUM_CH;
      chk("t3_grant", u_if.ready_o, 64'd1 << e);
      @(negedge clk);
      chk("t3_pulse", u_if.ready_o, 64'd0);
      @(negedge clk);
      chk("t3_out", {u_if.valid_o, u_if.ch_o, u_if.data_o}, {1'b1, 2'(e), 32'((e + 1) * 100)});
      @(negedge clk); #1;
    end
    u_if.valid_i = '0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
